onehot_decoder_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder, the successor to the team's fixed 3-to-8 combinational decoder. It accepts select codes over a valid/ready handshake and drives a one-hot (optionally active-low) output for a programmable number of cycles. It also has an autonomous scan mode that sweeps all outputs in turn. It sits between control logic and row/chip-select or LED/segment-select fabrics that need glitch-free, timed one-hot strobes.

---
 rtl/onehot_decoder_seq_pkg.sv | 13 +
 rtl/onehot_decoder_seq_if.sv | 27 ++
 rtl/onehot_decoder_seq_dec.sv | 14 +
 rtl/onehot_decoder_seq.sv | 134 +++++++++++++
 tb/tb_onehot_decoder_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types for the sequenced one-hot decoder: FSM state encoding and mode select values.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Select handshake and one-hot strobe bundle; master drives the request side, slave is the decoder.
interface onehot_decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] y;
  logic             y_valid;
  logic [SEL_W-1:0] idx;
  logic             busy;

  modport master (
    output en, mode, in_valid, sel,
    input  in_ready, y, y_valid, idx, busy
  );

  modport slave (
    input  en, mode, in_valid, sel,
    output in_ready, y, y_valid, idx, busy
  );

endinterface

// File: rtl/onehot_decoder_seq_dec.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decode; zero latency, no flow control.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [2**SEL_W-1:0]   dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder: an accepted sel appears on y the edge it is taken and holds HOLD_CYC cycles.
// in_ready is combinational and only high in IDLE or the final hold cycle; SCAN mode sweeps all outputs.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int HOLD_CYC   = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_seq_if.slave  bus
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [OUT_W-1:0] IDLE_PAT = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             busy_q;
  logic [OUT_W-1:0] dec;
  logic             last;
  logic             ready;
  logic             accept;

  assign last   = (cnt_q == CNT_LAST);
  assign ready  = !rst && bus.en && (bus.mode == MODE_DIRECT) &&
                  ((state_q == IDLE) || ((state_q == HOLD) && last));
  assign accept = ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = bus.sel;
            vld_d   = 1'b1;
          end else if (bus.mode == MODE_SCAN) begin
            state_d = SCAN;
            cnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b1;
          end
        end
        HOLD: begin
          // A mode change only takes effect once the current hold has run its full length.
          if (!last) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (accept) begin
            cnt_d = '0;
            idx_d = bus.sel;
          end else if (bus.mode == MODE_SCAN) begin
            state_d = SCAN;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
          end
        end
        SCAN: begin
          if (bus.mode != MODE_SCAN) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
          end else if (last) begin
            cnt_d = '0;
            idx_d = idx_q + SEL_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_i (idx_d),
    .dec_o (dec)
  );

  // Polarity is folded in before the register so y never glitches.
  assign y_d = vld_d ? (ACTIVE_LOW ? ~dec : dec) : IDLE_PAT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      y_q     <= IDLE_PAT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.in_ready = ready;
  assign bus.y        = y_q;
  assign bus.y_valid  = vld_q;
  assign bus.idx      = idx_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq covering DIRECT, back-to-back, SCAN, abort, reset and ACTIVE_LOW.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq_if #(.SEL_W(3)) ifa ();
  onehot_decoder_seq_if #(.SEL_W(3)) ifb ();
  onehot_decoder_seq_if #(.SEL_W(2)) ifc ();

  onehot_decoder_seq #(.SEL_W(3), .HOLD_CYC(2), .ACTIVE_LOW(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  onehot_decoder_seq #(.SEL_W(3), .HOLD_CYC(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));
  onehot_decoder_seq #(.SEL_W(2), .HOLD_CYC(2), .ACTIVE_LOW(1'b1)) dut_c (
    .clk (clk), .rst (rst), .bus (ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ifa.en = 1'b0; ifa.mode = 1'b0; ifa.in_valid = 1'b0; ifa.sel = '0;
    ifb.en = 1'b0; ifb.mode = 1'b0; ifb.in_valid = 1'b0; ifb.sel = '0;
    ifc.en = 1'b0; ifc.mode = 1'b0; ifc.in_valid = 1'b0; ifc.sel = '0;

    // Reset state, with a request pending to prove in_ready is gated by rst
    ifa.en = 1'b1; ifa.in_valid = 1'b1; ifa.sel = 3'd4;
    tick();
    chk("rst_y",      32'(ifa.y), 32'h00);
    chk("rst_yv",     32'(ifa.y_valid), 0);
    chk("rst_idx",    32'(ifa.idx), 0);
    chk("rst_busy",   32'(ifa.busy), 0);
    chk("rst_rdy",    32'(ifa.in_ready), 0);
    chk("rst_c_y",    32'(ifc.y), 32'hF);
    ifa.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_y",     32'(ifa.y), 32'h00);

    // Single accept sel=3, HOLD_CYC=2
    ifa.in_valid = 1'b1; ifa.sel = 3'd3;
    #1;
    chk("s3_rdy_idle", 32'(ifa.in_ready), 1);
    tick();
    ifa.in_valid = 1'b0;
    #1;
    chk("s3_y0",    32'(ifa.y), 32'h08);
    chk("s3_yv0",   32'(ifa.y_valid), 1);
    chk("s3_idx0",  32'(ifa.idx), 3);
    chk("s3_busy0", 32'(ifa.busy), 1);
    chk("s3_rdy0",  32'(ifa.in_ready), 0);
    tick();
    chk("s3_y1",    32'(ifa.y), 32'h08);
    chk("s3_rdy1",  32'(ifa.in_ready), 1);
    tick();
    chk("s3_y2",    32'(ifa.y), 32'h00);
    chk("s3_yv2",   32'(ifa.y_valid), 0);
    chk("s3_idx2",  32'(ifa.idx), 0);
    chk("s3_rdy2",  32'(ifa.in_ready), 1);

    // Back-to-back sel=1 then sel=6
    ifa.in_valid = 1'b1; ifa.sel = 3'd1;
    tick();
    ifa.sel = 3'd6;
    #1;
    chk("b2b_y0",  32'(ifa.y), 32'h02);
    tick();
    chk("b2b_y1",  32'(ifa.y), 32'h02);
    chk("b2b_yv1", 32'(ifa.y_valid), 1);
    tick();
    ifa.in_valid = 1'b0;
    chk("b2b_y2",  32'(ifa.y), 32'h40);
    chk("b2b_yv2", 32'(ifa.y_valid), 1);
    chk("b2b_ix2", 32'(ifa.idx), 6);
    tick();
    chk("b2b_y3",  32'(ifa.y), 32'h40);
    tick();
    chk("b2b_y4",  32'(ifa.y), 32'h00);

    // en dropped mid-hold aborts on the next edge
    ifa.in_valid = 1'b1; ifa.sel = 3'd5;
    tick();
    ifa.in_valid = 1'b0;
    chk("ab_y0",   32'(ifa.y), 32'h20);
    ifa.en = 1'b0;
    #1;
    chk("ab_rdy",  32'(ifa.in_ready), 0);
    tick();
    chk("ab_y1",   32'(ifa.y), 32'h00);
    chk("ab_yv1",  32'(ifa.y_valid), 0);
    chk("ab_busy", 32'(ifa.busy), 0);
    ifa.en = 1'b1;

    // mode switch mid-hold: hold completes, then SCAN from idx 0
    ifa.in_valid = 1'b1; ifa.sel = 3'd2;
    tick();
    ifa.in_valid = 1'b0;
    chk("ms_y0",   32'(ifa.y), 32'h04);
    ifa.mode = 1'b1;
    tick();
    chk("ms_y1",   32'(ifa.y), 32'h04);
    tick();
    chk("ms_y2",   32'(ifa.y), 32'h01);
    chk("ms_ix2",  32'(ifa.idx), 0);
    chk("ms_yv2",  32'(ifa.y_valid), 1);
    tick();
    chk("ms_y3",   32'(ifa.y), 32'h01);
    tick();
    chk("ms_y4",   32'(ifa.y), 32'h02);
    chk("ms_ix4",  32'(ifa.idx), 1);
    ifa.mode = 1'b0;
    tick();
    chk("ms_y5",   32'(ifa.y), 32'h00);
    chk("ms_bz5",  32'(ifa.busy), 0);

    // SCAN, HOLD_CYC=1, 10 cycles with wrap
    ifb.en = 1'b1; ifb.mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      tick();
      e = 32'h1 << (i % 8);
      chk($sformatf("scan_y%0d", i), 32'(ifb.y), e);
      chk($sformatf("scan_ix%0d", i), 32'(ifb.idx), 32'(i % 8));
    end
    ifb.mode = 1'b0;
    tick();
    chk("scan_off_y",  32'(ifb.y), 32'h00);
    chk("scan_off_yv", 32'(ifb.y_valid), 0);
    chk("scan_off_bz", 32'(ifb.busy), 0);

    // ACTIVE_LOW, SEL_W=2, sel=2
    ifc.en = 1'b1; ifc.in_valid = 1'b1; ifc.sel = 2'd2;
    chk("al_idle_y", 32'(ifc.y), 32'hF);
    tick();
    ifc.in_valid = 1'b0;
    chk("al_y0",   32'(ifc.y), 32'hB);
    chk("al_yv0",  32'(ifc.y_valid), 1);
    chk("al_ix0",  32'(ifc.idx), 2);
    tick();
    chk("al_y1",   32'(ifc.y), 32'hB);
    tick();
    chk("al_y2",   32'(ifc.y), 32'hF);
    chk("al_yv2",  32'(ifc.y_valid), 0);

    // Asynchronous reset mid-hold, sel=5
    ifa.in_valid = 1'b1; ifa.sel = 3'd5;
    tick();
    ifa.in_valid = 1'b0;
    chk("ar_y0",   32'(ifa.y), 32'h20);
    rst = 1'b1;
    #1;
    chk("ar_y",    32'(ifa.y), 32'h00);
    chk("ar_yv",   32'(ifa.y_valid), 0);
    chk("ar_idx",  32'(ifa.idx), 0);
    chk("ar_rdy",  32'(ifa.in_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_post_y",  32'(ifa.y), 32'h00);
    chk("ar_post_yv", 32'(ifa.y_valid), 0);
    tick();
    chk("ar_post2_y", 32'(ifa.y), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
